// File: rtl/pr_reset_pkg.sv
// Shared types and default timing for the PR sector reset sequencer.
// The per-sector FSM state encoding and the parameter range check live here.
package pr_reset_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FREEZE_PRE = 2'd1,
    RESET_HOLD = 2'd2,
    RELEASE    = 2'd3
  } sector_state_t;

  localparam int DEF_NUM_SECTORS = 8;
  localparam int DEF_FREEZE_LEAD = 4;
  localparam int DEF_MIN_RESET   = 16;
  localparam int DEF_RELEASE_LAG = 4;
  localparam int DEF_CNT_W       = 8;

  // A cycle count is loaded as value-1, so it must be at least 1 and fit the counter.
  function automatic bit cycle_param_ok(input int value, input int width);
    return (value >= 1) && (value < (1 << width));
  endfunction

endpackage

// File: rtl/pr_sector_reset_fsm.sv
// One PR sector: freeze -> reset (min width, held while requested) -> release lag -> ready.
// Outputs are registered decodes of the current state, one cycle behind it; req is never stalled.
module pr_sector_reset_fsm
  import pr_reset_pkg::*;
#(
  parameter int FREEZE_LEAD = DEF_FREEZE_LEAD,
  parameter int MIN_RESET   = DEF_MIN_RESET,
  parameter int RELEASE_LAG = DEF_RELEASE_LAG,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  output logic freeze,
  output logic rst_out,
  output logic ready,
  output logic active
);

  sector_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      freeze  <= 1'b0;
      rst_out <= 1'b0;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      freeze  <= (state_q != IDLE);
      rst_out <= (state_q == RESET_HOLD);
      ready   <= (state_q == IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = FREEZE_PRE;
          cnt_d   = CNT_W'(FREEZE_LEAD - 1);
        end
      end
      FREEZE_PRE: begin
        // A request that drops here still gets the full minimum reset pulse.
        if (cnt_q == '0) begin
          state_d = RESET_HOLD;
          cnt_d   = CNT_W'(MIN_RESET - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESET_HOLD: begin
        if (cnt_q == '0) begin
          if (!req) begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(RELEASE_LAG - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        // A fresh request re-enters reset without ever dropping freeze.
        if (req) begin
          state_d = RESET_HOLD;
          cnt_d   = CNT_W'(MIN_RESET - 1);
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign active = (state_q != IDLE);

endmodule

// File: rtl/pr_sector_reset_sequencer.sv
// Sequences freeze/reset/release for each PR sector from same-clock reset_source levels.
// Freeze rises 2 edges after reset_source is sampled high; no backpressure, each sector independent.
module pr_sector_reset_sequencer
  import pr_reset_pkg::*;
#(
  parameter int NUM_SECTORS = DEF_NUM_SECTORS,
  parameter int FREEZE_LEAD = DEF_FREEZE_LEAD,
  parameter int MIN_RESET   = DEF_MIN_RESET,
  parameter int RELEASE_LAG = DEF_RELEASE_LAG,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SECTORS-1:0] reset_source,
  output logic [NUM_SECTORS-1:0] sector_freeze,
  output logic [NUM_SECTORS-1:0] sector_reset,
  output logic [NUM_SECTORS-1:0] sector_ready,
  output logic                   busy
);

  if (!(cycle_param_ok(FREEZE_LEAD, CNT_W) && cycle_param_ok(MIN_RESET, CNT_W) &&
        cycle_param_ok(RELEASE_LAG, CNT_W))) begin : g_param_check
    $error("pr_sector_reset_sequencer: cycle parameter must be >= 1 and < 2**CNT_W");
  end

  logic [NUM_SECTORS-1:0] req_q;
  logic [NUM_SECTORS-1:0] active;

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q <= '0;
      busy  <= 1'b0;
    end else begin
      req_q <= reset_source;
      busy  <= |active;
    end
  end

  for (genvar i = 0; i < NUM_SECTORS; i++) begin : g_sector
    pr_sector_reset_fsm #(
      .FREEZE_LEAD(FREEZE_LEAD),
      .MIN_RESET  (MIN_RESET),
      .RELEASE_LAG(RELEASE_LAG),
      .CNT_W      (CNT_W)
    ) u_fsm (
      .clock  (clock),
      .reset  (reset),
      .req    (req_q[i]),
      .freeze (sector_freeze[i]),
      .rst_out(sector_reset[i]),
      .ready  (sector_ready[i]),
      .active (active[i])
    );
  end

endmodule
